apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max ACCESS wait cycles with PREADY low before abort; 0 disables timeout.
REQ-002 SHALL have port: PCLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: PRESETn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports m0_req/m1_req  input  1  requester i transfer request, held until m<i>_done.
REQ-005 SHALL have ports m0_write/m1_write  input  1  1=write, 0=read; stable while req high.
REQ-006 SHALL have ports m0_addr/m1_addr  input  32  transfer address; stable while req high.
REQ-007 SHALL have ports m0_wdata/m1_wdata  input  32  write data; stable while req high.
REQ-008 SHALL have ports m0_done/m1_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports m0_err/m1_err  output  1  error flag, valid only with matching done.
REQ-010 SHALL have port: rdata  output  32  read data, valid with done of a read, held until next read completion.
REQ-011 SHALL have port: busy  output  1  high in SETUP and ACCESS.
REQ-012 SHALL have APB master outputs: PSEL 1, PENABLE 1, PWRITE 1, PADDR 32, PWDATA 32.
REQ-013 SHALL have APB slave inputs: PRDATA 32, PREADY 1, PSLVERROR 1.

Function
REQ-014 SHALL implement states IDLE, SETUP, ACCESS.
REQ-015 IDLE: PSEL=0, PENABLE=0; on an eligible request, latch winner's write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP next edge.
REQ-016 Eligible = m<i>_req high AND m<i>_done low in the same cycle (the just-completed requester is not regranted during its done cycle).
REQ-017 Arbitration SHALL be round-robin: if both are eligible, grant the one not granted last; a single eligible requester always wins.
REQ-018 last_grant SHALL reset to 1, so requester 0 wins the first contention.
REQ-019 SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; remain while PREADY=0 and timeout is not reached.
REQ-021 On an ACCESS edge with PREADY=1: next state IDLE; next cycle m<g>_done=1, m<g>_err=PSLVERROR; on a read, rdata<=PRDATA, even when PSLVERROR=1.
REQ-022 Write completion SHALL leave rdata unchanged.
REQ-023 A 16-bit wait counter SHALL clear on SETUP entry, increment each ACCESS cycle with PREADY=0, and saturate.
REQ-024 If TIMEOUT>0 and the counter equals TIMEOUT while PREADY=0, the block SHALL abort: next state IDLE, done=1, err=1, rdata unchanged.
REQ-025 Minimum transfer cost SHALL be 3 cycles (SETUP, ACCESS, IDLE/done); back-to-back grants have one IDLE cycle between transfers.
REQ-026 PADDR/PWRITE/PWDATA SHALL hold their values from grant through IDLE until the next grant.
REQ-027 Requester deasserting req mid-transfer SHALL NOT abort; the transfer completes and done still pulses.
REQ-028 A new request arriving during SETUP/ACCESS SHALL wait; it is evaluated in the next IDLE cycle.
REQ-029 At most one done output SHALL be high in any cycle.

Reset
REQ-030 PRESETn low SHALL immediately force state IDLE, PSEL=0, PENABLE=0, busy=0, all done/err=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, counter=0, last_grant=1.
REQ-031 Reset during SETUP/ACCESS SHALL drop the transfer with no done pulse.
REQ-032 The first grant after reset release SHALL be at the first rising edge with PRESETn high and an eligible request.

Verification
REQ-033 m0 read 0x100, PREADY=1, PRDATA=0xDEADBEEF -> PSEL 2 cycles, PENABLE 1 cycle, m0_done pulse with rdata=0xDEADBEEF, m0_err=0.
REQ-034 m0 and m1 both request writes from reset -> m0 served first, then m1; m1 PSEL rises 1 IDLE cycle after m0_done; order alternates if both keep requesting.
REQ-035 m1 write, PREADY low for 5 cycles, then PREADY=1 with PSLVERROR=1 -> ACCESS lasts 6 cycles, PADDR/PWDATA stable, m1_done with m1_err=1.
REQ-036 TIMEOUT=4, PREADY stuck 0 -> abort after 4 wait cycles, done with err=1, PSEL=0 next cycle, rdata unchanged.
REQ-037 PRESETn asserted during ACCESS -> PSEL/PENABLE low immediately, no done; after release, a pending m0_req is granted.

Source files
------------

// File: rtl/apb_master_arb.sv
// Two-requester APB master with round-robin arbitration and an optional
// ACCESS-phase wait-state timeout that aborts the transfer with an error.
module apb_master_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,

    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic        m1_err,

    output logic [31:0] rdata,
    output logic        busy,

    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERROR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic        TIMEOUT_EN  = (TIMEOUT != 0);

    logic [1:0]  state_q, state_d;
    logic        lastGrant_q, lastGrant_d;
    logic        owner_q, owner_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [15:0] waitCnt_q, waitCnt_d;

    logic elig0, elig1, winner, timeoutHit, finish, finishErr;

    // A requester is not regranted during the cycle its done pulse is shown.
    assign elig0      = m0_req & ~done0_q;
    assign elig1      = m1_req & ~done1_q;
    assign winner     = (elig0 && elig1) ? ~lastGrant_q : elig1;
    assign timeoutHit = TIMEOUT_EN && (waitCnt_q == TIMEOUT_CNT);

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rdata_d     = rdata_q;
        waitCnt_d   = waitCnt_q;
        finish      = 1'b0;
        finishErr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_d     = SETUP;
                    owner_d     = winner;
                    lastGrant_d = winner;
                    pwrite_d    = winner ? m1_write : m0_write;
                    paddr_d     = winner ? m1_addr  : m0_addr;
                    pwdata_d    = winner ? m1_wdata : m0_wdata;
                    waitCnt_d   = 16'd0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d   = IDLE;
                    finish    = 1'b1;
                    finishErr = PSLVERROR;
                    if (!pwrite_q) rdata_d = PRDATA;
                end else if (timeoutHit) begin
                    state_d   = IDLE;
                    finish    = 1'b1;
                    finishErr = 1'b1;
                end else if (waitCnt_q != 16'hFFFF) begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        done0_d = finish & ~owner_q;
        done1_d = finish &  owner_q;
        err0_d  = finishErr & ~owner_q;
        err1_d  = finishErr &  owner_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            rdata_q     <= 32'd0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            waitCnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rdata_q     <= rdata_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            waitCnt_q   <= waitCnt_d;
        end
    end

    assign PSEL    = (state_q != IDLE);
    assign PENABLE = (state_q == ACCESS);
    assign busy    = PSEL;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign rdata   = rdata_q;
    assign m0_done = done0_q;
    assign m1_done = done1_q;
    assign m0_err  = err0_q;
    assign m1_err  = err1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Randomized scoreboard bench for apb_master_arb: a transaction-level model of
// the requesters and arbiter predicts each completion, a monitor checks dones.
module tb_apb_master_arb;

    // Small timeout so random slave delays exercise both completion and abort.
    localparam int unsigned T = 6;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        reqV[2];
    logic        wrV[2];
    logic [31:0] addrV[2];
    logic [31:0] wdataV[2];
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [31:0] rdata;
    logic        busy, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERROR;

    apb_master_arb #(.TIMEOUT(T)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .m0_req(reqV[0]), .m0_write(wrV[0]), .m0_addr(addrV[0]), .m0_wdata(wdataV[0]),
        .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(reqV[1]), .m1_write(wrV[1]), .m1_addr(addrV[1]), .m1_wdata(wdataV[1]),
        .m1_done(m1_done), .m1_err(m1_err),
        .rdata(rdata), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERROR(PSLVERROR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { bit who; bit err; logic [31:0] rd; } exp_t;
    exp_t qExp[$];

    int checks = 0, failures = 0;
    int cycle = 0;
    bit randomOn = 0;
    bit pending[2], inService[2];
    int earliest[2], gapCnt[2], lastDoneCycle[2], lastSetupCycle[2];
    bit lastServed = 1;
    logic [31:0] expRdata = 32'd0;
    bit prevPsel = 0;
    int accessCnt = 0, waitTarget = 0;
    logic [31:0] slvData;
    bit slvErr;
    bit ovValid = 0, ovErr = 0;
    int ovWait = 0;
    logic [31:0] ovData = 32'd0;
    logic [31:0] curAddr, curWdata;
    bit curWrite;
    int pselCnt = 0, penCnt = 0, grantCount = 0, doneSeen = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=event required=none (cycle %0d)", name, cycle);
    endtask

    task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        wrV[i] = w;
        addrV[i] = a;
        wdataV[i] = d;
        reqV[i] = 1'b1;
        pending[i] = 1'b1;
        // Raised during its own done cycle, the request is only seen one edge later.
        earliest[i] = cycle + ((((i == 0) ? m0_done : m1_done) == 1'b1) ? 2 : 1);
    endtask

    task automatic onSetup();
        bit c0, c1, who;
        exp_t e;
        if (ovValid) begin
            waitTarget = ovWait; slvData = ovData; slvErr = ovErr; ovValid = 0;
        end else begin
            waitTarget = int'($urandom_range(0, 9));
            slvData = $urandom;
            slvErr = ($urandom_range(0, 3) == 0);
        end
        c0 = pending[0] && (earliest[0] <= cycle);
        c1 = pending[1] && (earliest[1] <= cycle);
        if (!c0 && !c1) begin
            failNow("spurious_grant");
            return;
        end
        who = (c0 && c1) ? !lastServed : c1;
        checkOutput("grant_addr", PADDR, addrV[who]);
        checkOutput("grant_write", 32'(PWRITE), 32'(wrV[who]));
        checkOutput("grant_wdata", PWDATA, wdataV[who]);
        pending[who] = 0;
        inService[who] = 1;
        lastServed = who;
        lastSetupCycle[who] = cycle;
        curAddr = addrV[who]; curWrite = wrV[who]; curWdata = wdataV[who];
        grantCount++;
        e.who = who;
        e.err = (waitTarget > int'(T)) ? 1'b1 : slvErr;
        if (!curWrite && waitTarget <= int'(T)) expRdata = slvData;
        e.rd = expRdata;
        qExp.push_back(e);
    endtask

    // One clock of bench activity: observe the DUT, play slave, play requesters.
    task automatic applyStimulus();
        bit doneNow[2];
        @(negedge PCLK);
        cycle++;
        doneNow[0] = m0_done;
        doneNow[1] = m1_done;
        if (PSEL) pselCnt++;
        if (PENABLE) penCnt++;
        if (PRESETn) begin
            if (PSEL && !PENABLE) onSetup();
            else if (PSEL) begin
                checkOutput("hold_addr", PADDR, curAddr);
                checkOutput("hold_wdata", PWDATA, curWdata);
                checkOutput("hold_write", 32'(PWRITE), 32'(curWrite));
            end
            if (!PSEL && !prevPsel)
                for (int i = 0; i < 2; i++)
                    if (pending[i] && earliest[i] <= cycle) failNow("grant_latency");
        end
        prevPsel = PSEL;
        if (PSEL && PENABLE) begin
            PREADY = (accessCnt == waitTarget);
            PRDATA = PREADY ? slvData : $urandom;
            PSLVERROR = PREADY ? slvErr : 1'($urandom);
            accessCnt++;
        end else begin
            PREADY = 1'b0;
            PSLVERROR = 1'b0;
            accessCnt = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (doneNow[i]) begin
                lastDoneCycle[i] = cycle;
                inService[i] = 0;
                if (randomOn && $urandom_range(0, 2) == 0)
                    issue(i, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
                else begin
                    reqV[i] = 1'b0;
                    gapCnt[i] = int'($urandom_range(0, 4));
                end
            end else if (randomOn && !reqV[i]) begin
                if (gapCnt[i] == 0) issue(i, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
                else gapCnt[i]--;
            end
        end
    endtask

    task automatic waitDone(input int maxCycles);
        int n = 0;
        while ((pending[0] || pending[1] || inService[0] || inService[1] || busy) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        if (n >= maxCycles) failNow("wait_timeout");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (m0_done && m1_done) failNow("two_done");
            else if (m0_done || m1_done) begin
                doneSeen++;
                if (qExp.size() == 0) failNow("unexpected_done");
                else begin
                    e = qExp.pop_front();
                    checkOutput("done_who", 32'(m1_done), 32'(e.who));
                    checkOutput("done_err", 32'(m1_done ? m1_err : m0_err), 32'(e.err));
                    checkOutput("done_rdata", rdata, e.rd);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            reqV[i] = 0; wrV[i] = 0; addrV[i] = 0; wdataV[i] = 0;
            pending[i] = 0; inService[i] = 0; earliest[i] = 0; gapCnt[i] = 0;
            lastDoneCycle[i] = 0; lastSetupCycle[i] = 0;
        end
        PREADY = 0; PRDATA = 0; PSLVERROR = 0;
        PRESETn = 1'b0;
        #12;
        checkOutput("rst_psel", 32'(PSEL), 32'd0);
        checkOutput("rst_penable", 32'(PENABLE), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'({m0_done, m1_done, m0_err, m1_err}), 32'd0);
        checkOutput("rst_pwrite", 32'(PWRITE), 32'd0);
        checkOutput("rst_paddr", PADDR, 32'd0);
        checkOutput("rst_pwdata", PWDATA, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        applyStimulus();
        PRESETn = 1'b1;

        // Both requesters write at once from reset: m0 first, m1 one IDLE cycle after m0_done.
        issue(0, 1'b1, 32'h0000_0200, 32'hA5A5_0001);
        issue(1, 1'b1, 32'h0000_0300, 32'h5A5A_0002);
        waitDone(60);
        checkOutput("rr_first_m0", 32'(lastSetupCycle[0] < lastSetupCycle[1]), 32'd1);
        checkOutput("rr_gap", 32'(lastSetupCycle[1]), 32'(lastDoneCycle[0] + 1));

        // Zero-wait read.
        ovValid = 1; ovWait = 0; ovData = 32'hDEAD_BEEF; ovErr = 0;
        pselCnt = 0; penCnt = 0;
        issue(0, 1'b0, 32'h0000_0100, 32'h0);
        waitDone(30);
        checkOutput("rd_psel_cycles", 32'(pselCnt), 32'd2);
        checkOutput("rd_penable_cycles", 32'(penCnt), 32'd1);

        // Write with five wait states and slave error.
        ovValid = 1; ovWait = 5; ovData = 32'h1111_1111; ovErr = 1;
        penCnt = 0;
        issue(1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D);
        waitDone(40);
        checkOutput("wait_penable_cycles", 32'(penCnt), 32'd6);

        // Slave never ready: abort after T wait cycles.
        ovValid = 1; ovWait = 1000; ovData = 32'h2222_2222; ovErr = 0;
        penCnt = 0;
        issue(0, 1'b0, 32'h0000_0500, 32'h0);
        waitDone(40);
        checkOutput("timeout_penable_cycles", 32'(penCnt), 32'(T + 1));

        // Reset in the middle of ACCESS drops the transfer; the held request is regranted.
        ovValid = 1; ovWait = 1000; ovData = 32'h3333_3333; ovErr = 0;
        issue(0, 1'b0, 32'h0000_0600, 32'h0);
        begin
            int n = 0;
            while (!PENABLE && n < 20) begin applyStimulus(); n++; end
            if (n >= 20) failNow("access_wait_timeout");
        end
        applyStimulus();
        PRESETn = 1'b0;
        #1;
        checkOutput("arst_psel", 32'(PSEL), 32'd0);
        checkOutput("arst_penable", 32'(PENABLE), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_rdata", rdata, 32'd0);
        qExp.delete();
        grantCount--;
        inService[0] = 0; pending[0] = 1; earliest[0] = 32'h3FFF_FFFF;
        lastServed = 1; expRdata = 32'd0;
        applyStimulus();
        applyStimulus();
        ovValid = 1; ovWait = 0; ovData = 32'h1234_5678; ovErr = 0;
        PRESETn = 1'b1;
        earliest[0] = cycle + 1;
        waitDone(30);

        // Randomized traffic from both requesters.
        for (int i = 0; i < 2; i++) gapCnt[i] = int'($urandom_range(0, 3));
        randomOn = 1;
        repeat (3000) applyStimulus();
        randomOn = 0;
        waitDone(300);
        applyStimulus();
        checkOutput("done_count", 32'(doneSeen), 32'(grantCount));
        checkOutput("queue_empty", 32'(qExp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
